// File: rtl/cpu_pkg.sv
// Shared CPU constants for the writeback/register-file slice.
// Register 0 is architecturally hardwired to zero.
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bus plus the ID-stage read ports of the register file.
// master = pipeline side, slave = register file.
interface wb_regfile_if
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DATA_W,
  parameter int AW = cpu_pkg::ADDR_W
);
  logic          WB_reg_write;
  logic          WB_mem_to_reg;
  logic [DW-1:0] WB_mem_data;
  logic [DW-1:0] WB_alu_result;
  logic [AW-1:0] WB_mux_out;
  logic [AW-1:0] ID_rs_addr;
  logic [AW-1:0] ID_rt_addr;
  logic [DW-1:0] ID_rs_data;
  logic [DW-1:0] ID_rt_data;
  logic [DW-1:0] WB_write_data;
  logic [31:0]   wb_count;

  modport master (
    output WB_reg_write, WB_mem_to_reg, WB_mem_data, WB_alu_result, WB_mux_out,
    output ID_rs_addr, ID_rt_addr,
    input  ID_rs_data, ID_rt_data, WB_write_data, wb_count
  );

  modport slave (
    input  WB_reg_write, WB_mem_to_reg, WB_mem_data, WB_alu_result, WB_mux_out,
    input  ID_rs_addr, ID_rt_addr,
    output ID_rs_data, ID_rt_data, WB_write_data, wb_count
  );
endinterface

// File: rtl/wb_mux.sv
// Writeback source select: load data or ALU result, independent of the
// write enable so the forwarding unit always sees the candidate value.
module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] write_data
);
  assign write_data = mem_to_reg ? mem_data : alu_result;
endmodule

// File: rtl/wb_regfile.sv
// Architectural register file at the WB stage: 32 entries, two async read
// ports, commit counter. Define WB_BYPASS_EN for same-cycle write-to-read bypass.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         startin,
  wb_regfile_if.slave  bus
);
  localparam int REG_COUNT = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [31:0]       wb_count_q;
  logic [DATA_W-1:0] write_data;
  logic              commit;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .mem_to_reg (bus.WB_mem_to_reg),
    .mem_data   (bus.WB_mem_data),
    .alu_result (bus.WB_alu_result),
    .write_data (write_data)
  );

  // Writes to r0 are discarded and must not advance the counter.
  assign commit = !startin && bus.WB_reg_write && (bus.WB_mux_out != REG_ZERO);

  always_ff @(posedge clk) begin
    if (startin) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      wb_count_q <= '0;
    end else if (commit) begin
      regs[bus.WB_mux_out] <= write_data;
      wb_count_q           <= wb_count_q + 32'd1;
    end
  end

  always_comb begin
    rs_data = (bus.ID_rs_addr == REG_ZERO) ? '0 : regs[bus.ID_rs_addr];
    rt_data = (bus.ID_rt_addr == REG_ZERO) ? '0 : regs[bus.ID_rt_addr];
`ifdef WB_BYPASS_EN
    // commit already excludes r0, so address 0 can never pick up the bypass.
    if (commit && (bus.ID_rs_addr == bus.WB_mux_out)) rs_data = write_data;
    if (commit && (bus.ID_rt_addr == bus.WB_mux_out)) rt_data = write_data;
`endif
  end

  assign bus.ID_rs_data    = rs_data;
  assign bus.ID_rt_data    = rt_data;
  assign bus.WB_write_data = write_data;
  assign bus.wb_count      = wb_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: array model compared every cycle plus
// hand-computed literal expectations. Honours WB_BYPASS_EN like the DUT.
module tb_wb_regfile;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic startin;
  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk     (clk),
    .startin (startin),
    .bus     (bus)
  );

  logic [31:0] model_regs [32];
  logic [31:0] model_count;
  logic        model_valid;

  logic        lit_rs_en, lit_rt_en, lit_wd_en, lit_cnt_en;
  logic [31:0] lit_rs, lit_rt, lit_wd, lit_cnt;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] modelWriteData();
    return bus.WB_mem_to_reg ? bus.WB_mem_data : bus.WB_alu_result;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (!startin && bus.WB_reg_write && bus.WB_mux_out != 5'd0 && a == bus.WB_mux_out)
      return modelWriteData();
`endif
    return model_regs[a];
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    if (model_valid) begin
      compare("model_rs", bus.ID_rs_data, modelRead(bus.ID_rs_addr));
      compare("model_rt", bus.ID_rt_data, modelRead(bus.ID_rt_addr));
      compare("model_wd", bus.WB_write_data, modelWriteData());
      compare("model_cnt", bus.wb_count, model_count);
    end
    if (lit_rs_en)  compare("lit_rs", bus.ID_rs_data, lit_rs);
    if (lit_rt_en)  compare("lit_rt", bus.ID_rt_data, lit_rt);
    if (lit_wd_en)  compare("lit_wd", bus.WB_write_data, lit_wd);
    if (lit_cnt_en) compare("lit_cnt", bus.wb_count, lit_cnt);
  endtask

  // Outputs are sampled mid-cycle, with inputs stable since just after the rising edge.
  always @(negedge clk) checkOutput();

  task automatic applyStimulus(input logic rst, input logic we, input logic m2r,
                               input logic [31:0] mem, input logic [31:0] alu,
                               input logic [4:0] dest, input logic [4:0] rs,
                               input logic [4:0] rt);
    startin           = rst;
    bus.WB_reg_write  = we;
    bus.WB_mem_to_reg = m2r;
    bus.WB_mem_data   = mem;
    bus.WB_alu_result = alu;
    bus.WB_mux_out    = dest;
    bus.ID_rs_addr    = rs;
    bus.ID_rt_addr    = rt;
    lit_rs_en  = 1'b0;
    lit_rt_en  = 1'b0;
    lit_wd_en  = 1'b0;
    lit_cnt_en = 1'b0;
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, rs, rt);
  endtask

  task automatic expectRs(input logic [31:0] v);  lit_rs_en = 1'b1;  lit_rs = v;  endtask
  task automatic expectRt(input logic [31:0] v);  lit_rt_en = 1'b1;  lit_rt = v;  endtask
  task automatic expectWd(input logic [31:0] v);  lit_wd_en = 1'b1;  lit_wd = v;  endtask
  task automatic expectCnt(input logic [31:0] v); lit_cnt_en = 1'b1; lit_cnt = v; endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic step();
    @(posedge clk);
    if (startin) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
    end else if (bus.WB_reg_write && bus.WB_mux_out != 5'd0) begin
      model_regs[bus.WB_mux_out] = modelWriteData();
      model_count = model_count + 32'd1;
    end
    model_valid = 1'b1;
    #1;
  endtask

  initial begin
    model_valid = 1'b0;
    model_count = 32'd0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    step();
    step();

    idle(5'd0, 5'd0);
    expectRs(32'd0); expectCnt(32'd0);
    step();

    // Preload r5, then reset with a write to r7 pending in the same cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_1234, 5'd5, 5'd5, 5'd7);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0077, 5'd7, 5'd5, 5'd7);
    expectRs(32'h0000_1234); expectRt(32'd0); expectCnt(32'd1);
    step();
    idle(5'd5, 5'd7);
    expectRs(32'd0); expectRt(32'd0); expectCnt(32'd0);
    step();

    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'hDEAD_BEEF, 5'd9, 5'd9, 5'd0);
    expectWd(32'hDEAD_BEEF); expectCnt(32'd0);
    step();
    idle(5'd9, 5'd0);
    expectRs(32'hDEAD_BEEF); expectCnt(32'd1);
    step();

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_ABCD, 32'hFFFF_FFFF, 5'd17, 5'd0, 5'd9);
    expectWd(32'h0000_ABCD); expectRt(32'hDEAD_BEEF);
    step();
    idle(5'd0, 5'd17);
    expectRt(32'h0000_ABCD); expectCnt(32'd2);
    step();

    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0055, 5'd0, 5'd0, 5'd0);
    expectRs(32'd0); expectRt(32'd0); expectWd(32'h0000_0055);
    step();
    idle(5'd0, 5'd0);
    expectRs(32'd0); expectCnt(32'd2);
    step();

    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0011, 5'd3, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_0022, 5'd3, 5'd3, 5'd3);
`ifdef WB_BYPASS_EN
    expectRs(32'h0000_0022); expectRt(32'h0000_0022);
`else
    expectRs(32'h0000_0011); expectRt(32'h0000_0011);
`endif
    expectCnt(32'd3);
    step();
    idle(5'd3, 5'd3);
    expectRs(32'h0000_0022); expectRt(32'h0000_0022); expectCnt(32'd4);
    step();

    // Jump the counter to its top value to exercise the wrap.
    idle(5'd4, 5'd3);
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    model_count = 32'hFFFF_FFFF;
    expectCnt(32'hFFFF_FFFF);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'h0000_CAFE, 5'd4, 5'd4, 5'd0);
    expectCnt(32'hFFFF_FFFF);
    step();
    idle(5'd4, 5'd17);
    expectRs(32'h0000_CAFE); expectRt(32'h0000_ABCD); expectCnt(32'd0);
    step();

    for (int i = 1; i < 32; i += 5) begin
      applyStimulus(1'b0, 1'b1, i[0], 32'hA500_0000 + i, 32'h5A00_0000 + i,
                    i[4:0], i[4:0], 5'(i - 1));
      step();
    end
    for (int i = 0; i < 32; i += 3) begin
      idle(i[4:0], 5'(31 - i));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
